// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_arb_pkg
// Brief    : Shared types, widths and field-slicing helpers for i2c_bus_arbiter
// Revision : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

  localparam int IIC_DW  = 32;
  localparam int IIC_CW  = 8;
  localparam int IIC_RW  = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_RUN     = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // Callers zero-extend their packed bus to MAX_REQ slots so one helper fits any NUM_REQ.
  function automatic logic [IIC_DW-1:0] slice_word(input logic [IIC_DW*MAX_REQ-1:0] vec,
                                                   input int idx);
    return vec[idx*IIC_DW +: IIC_DW];
  endfunction

  function automatic logic [IIC_CW-1:0] slice_byte(input logic [IIC_CW*MAX_REQ-1:0] vec,
                                                   input int idx);
    return vec[idx*IIC_CW +: IIC_CW];
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin one-hot select, searching upward from last+1
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  always_comb begin
    int cand;
    cand    = 0;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(i_last) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!o_valid && i_req[IW'(cand)]) begin
        o_valid            = 1'b1;
        o_idx              = IW'(cand);
        o_gnt[IW'(cand)]   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_arbiter
// Brief    : Round-robin, whole-transaction sharing of one uii2c master with watchdog
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int TO_W        = 21
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [IIC_DW*NUM_REQ-1:0] req_wr_data_i,
  input  logic [IIC_CW*NUM_REQ-1:0] req_wr_cnt_i,
  input  logic [IIC_CW*NUM_REQ-1:0] req_rd_cnt_i,
  input  logic [NUM_REQ-1:0]        req_mode_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [IIC_RW-1:0]         rd_data_o,
  output logic                      iic_en,
  output logic [IIC_DW-1:0]         iic_wr_data,
  output logic [IIC_CW-1:0]         iic_wr_cnt,
  output logic [IIC_CW-1:0]         iic_rd_cnt,
  output logic                      iic_mode,
  input  logic [IIC_RW-1:0]         iic_rd_data,
  input  logic                      iic_busy
);

  localparam int              c_iw       = $clog2(NUM_REQ);
  localparam int              c_dw_all   = IIC_DW * MAX_REQ;
  localparam int              c_cw_all   = IIC_CW * MAX_REQ;
  localparam logic [TO_W-1:0] c_to_last  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [c_iw-1:0] c_last_rst = c_iw'(NUM_REQ - 1);

  arb_state_t          r_state;
  logic [c_iw-1:0]     r_last;
  logic [TO_W-1:0]     r_wd;

  logic [NUM_REQ-1:0]  w_pick_gnt;
  logic [c_iw-1:0]     w_pick_idx;
  logic                w_pick_valid;
  logic [c_dw_all-1:0] w_wd_ext;
  logic [c_cw_all-1:0] w_wc_ext;
  logic [c_cw_all-1:0] w_rc_ext;
  logic                w_timeout;

  assign w_wd_ext  = c_dw_all'(req_wr_data_i);
  assign w_wc_ext  = c_cw_all'(req_wr_cnt_i);
  assign w_rc_ext  = c_cw_all'(req_rd_cnt_i);
  assign w_timeout = (r_wd == c_to_last);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (c_iw)
  ) u_rr_pick (
    .i_req   (req_i),
    .i_last  (r_last),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= c_last_rst;
      r_wd        <= '0;
      gnt_o       <= '0;
      done_o      <= '0;
      err_o       <= '0;
      rd_data_o   <= '0;
      iic_en      <= 1'b0;
      iic_wr_data <= '0;
      iic_wr_cnt  <= '0;
      iic_rd_cnt  <= '0;
      iic_mode    <= 1'b0;
    end else begin
      done_o <= '0;
      err_o  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            gnt_o       <= w_pick_gnt;
            iic_en      <= 1'b1;
            r_last      <= w_pick_idx;
            r_wd        <= '0;
            iic_wr_data <= slice_word(w_wd_ext, int'(w_pick_idx));
            iic_wr_cnt  <= slice_byte(w_wc_ext, int'(w_pick_idx));
            iic_rd_cnt  <= slice_byte(w_rc_ext, int'(w_pick_idx));
            iic_mode    <= req_mode_i[w_pick_idx];
            r_state     <= ST_LAUNCH;
          end
        end
        // Busy already high on entry means the master is draining a timed-out
        // transfer; it will not accept a new start until idle, so treat it as taken.
        ST_LAUNCH: begin
          r_wd <= r_wd + 1'b1;
          if (iic_busy) begin
            iic_en  <= 1'b0;
            r_state <= ST_RUN;
          end else if (w_timeout) begin
            iic_en  <= 1'b0;
            err_o   <= gnt_o;
            r_state <= ST_RELEASE;
          end
        end
        ST_RUN: begin
          r_wd <= r_wd + 1'b1;
          if (!iic_busy) begin
            rd_data_o <= iic_rd_data;
            done_o    <= gnt_o;
            r_state   <= ST_RELEASE;
          end else if (w_timeout) begin
            err_o   <= gnt_o;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          gnt_o   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_arbiter
// Brief    : Vector table + scoreboard bench for i2c_bus_arbiter with a uii2c busy model
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_arbiter;
  import i2c_arb_pkg::*;

  localparam int N   = 2;
  localparam int TO  = 400;
  localparam int TOW = 9;

  logic           clk_i = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [32*N-1:0] req_wr_data_i = '0;
  logic [8*N-1:0] req_wr_cnt_i = '0;
  logic [8*N-1:0] req_rd_cnt_i = '0;
  logic [N-1:0]   req_mode_i = '0;
  logic [N-1:0]   gnt_o, done_o, err_o;
  logic [7:0]     rd_data_o;
  logic           iic_en;
  logic [31:0]    iic_wr_data;
  logic [7:0]     iic_wr_cnt, iic_rd_cnt;
  logic           iic_mode;
  logic [7:0]     iic_rd_data = '0;
  logic           iic_busy = 1'b0;

  int busy_len = 300;
  bit mute = 1'b0;
  int m_dly = 0;
  int m_cnt = 0;
  int checks = 0;
  int failures = 0;

  i2c_bus_arbiter #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (TO),
    .TO_W        (TOW)
  ) dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .req_wr_data_i (req_wr_data_i),
    .req_wr_cnt_i  (req_wr_cnt_i),
    .req_rd_cnt_i  (req_rd_cnt_i),
    .req_mode_i    (req_mode_i),
    .gnt_o         (gnt_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .rd_data_o     (rd_data_o),
    .iic_en        (iic_en),
    .iic_wr_data   (iic_wr_data),
    .iic_wr_cnt    (iic_wr_cnt),
    .iic_rd_cnt    (iic_rd_cnt),
    .iic_mode      (iic_mode),
    .iic_rd_data   (iic_rd_data),
    .iic_busy      (iic_busy)
  );

  always #20 clk_i = ~clk_i;

  // Master model: busy rises 2 cycles after a start is seen, stays high busy_len cycles.
  always @(posedge clk_i) begin
    if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) iic_busy <= 1'b0;
    end else if (m_dly > 0) begin
      m_dly <= m_dly - 1;
      if (m_dly == 1) begin
        iic_busy <= 1'b1;
        m_cnt    <= busy_len;
      end
    end else if (iic_en && !iic_busy && !mute) begin
      m_dly <= 1;
    end
  end

  typedef struct {
    bit          rst;
    logic [1:0]  req;
    logic [63:0] wdata;
    logic [15:0] wcnt;
    logic [15:0] rcnt;
    logic [1:0]  mode;
    logic [7:0]  rd_val;
    int          blen;
    bit          mt;
    bit          poke;
    logic [1:0]  egnt;
    bit          eerr;
    logic [7:0]  erd;
  } vec_t;

  typedef struct {
    logic [1:0]  gnt;
    bit          err;
    logic [7:0]  rd;
    logic [31:0] wd;
    logic [7:0]  wc;
    logic [7:0]  rc;
    logic        mode;
    int          en_cyc;
    bit          poke;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];

  function automatic vec_t mkv(bit rst, logic [1:0] req, logic [63:0] wd, logic [15:0] wc,
                               logic [15:0] rc, logic [1:0] mode, logic [7:0] rdv, int blen,
                               bit mt, bit pk, logic [1:0] eg, bit ee, logic [7:0] erd);
    vec_t v;
    v.rst = rst; v.req = req; v.wdata = wd; v.wcnt = wc; v.rcnt = rc; v.mode = mode;
    v.rd_val = rdv; v.blen = blen; v.mt = mt; v.poke = pk; v.egnt = eg; v.eerr = ee; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, want);
    end
  endtask

  task automatic do_txn(input string tag);
    exp_t e;
    int   cyc;
    int   en_cyc;
    int   fall_cyc;
    bit   busy_seen;
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 64'(exp_q.size()), 64'd1);
      return;
    end
    e = exp_q.pop_front();
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (gnt_o == '0 && cyc < 50);
    chk({tag, " gnt"}, 64'(gnt_o), 64'(e.gnt));
    chk({tag, " grant_latency"}, 64'(cyc), 64'd1);
    chk({tag, " en_at_grant"}, 64'(iic_en), 64'd1);
    chk({tag, " wr_data"}, 64'(iic_wr_data), 64'(e.wd));
    chk({tag, " wr_cnt"}, 64'(iic_wr_cnt), 64'(e.wc));
    chk({tag, " rd_cnt"}, 64'(iic_rd_cnt), 64'(e.rc));
    chk({tag, " mode"}, 64'(iic_mode), 64'(e.mode));
    en_cyc = 0; fall_cyc = -1; busy_seen = 1'b0; cyc = 0;
    while (done_o == '0 && err_o == '0 && cyc < TO + 100) begin
      if (iic_en) en_cyc++;
      if (iic_busy) busy_seen = 1'b1;
      else if (busy_seen && fall_cyc < 0) fall_cyc = cyc;
      if (e.poke && cyc == 5) begin
        req_wr_data_i[31:0] = 32'hFFFF_0000;
        req_wr_cnt_i[7:0]   = 8'hEE;
        req_mode_i[0]       = ~req_mode_i[0];
        req_i               = '0;
      end
      @(negedge clk_i);
      cyc++;
    end
    chk({tag, " done"}, 64'(done_o), e.err ? 64'd0 : 64'(e.gnt));
    chk({tag, " err"}, 64'(err_o), e.err ? 64'(e.gnt) : 64'd0);
    chk({tag, " en_cycles"}, 64'(en_cyc), 64'(e.en_cyc));
    if (!e.err) begin
      chk({tag, " rd_data"}, 64'(rd_data_o), 64'(e.rd));
      chk({tag, " done_after_fall"}, 64'(cyc - fall_cyc), 64'd1);
    end
    @(negedge clk_i);
    chk({tag, " pulse_clear"}, 64'({done_o, err_o}), 64'd0);
    chk({tag, " gnt_release"}, 64'(gnt_o), 64'd0);
    chk({tag, " wr_data_held"}, 64'(iic_wr_data), 64'(e.wd));
    chk({tag, " wr_cnt_held"}, 64'(iic_wr_cnt), 64'(e.wc));
    chk({tag, " mode_held"}, 64'(iic_mode), 64'(e.mode));
    if (!e.err) chk({tag, " rd_held"}, 64'(rd_data_o), 64'(e.rd));
  endtask

  task automatic push_exp(input logic [1:0] g, input bit er, input logic [7:0] rd,
                          input logic [31:0] wd, input logic [7:0] wc, input logic [7:0] rc,
                          input logic md, input int en, input bit pk);
    exp_t e;
    e.gnt = g; e.err = er; e.rd = rd; e.wd = wd; e.wc = wc; e.rc = rc;
    e.mode = md; e.en_cyc = en; e.poke = pk;
    exp_q.push_back(e);
  endtask

  initial begin
    vec_t v;
    bit   w;
    int   cyc;
    vecs[0] = mkv(1, 2'b01, {32'hDEAD_BEEF, 32'h1208_3078}, {8'd3, 8'd4}, 16'h0000, 2'b00,
                  8'h11, 300, 0, 0, 2'b01, 0, 8'h11);
    vecs[1] = mkv(1, 2'b11, {32'h1111_2222, 32'h3333_4444}, {8'd2, 8'd3}, {8'd1, 8'd0}, 2'b10,
                  8'h3C, 20, 0, 0, 2'b01, 0, 8'h3C);
    vecs[2] = mkv(0, 2'b11, {32'h1111_2222, 32'h3333_4444}, {8'd2, 8'd3}, {8'd1, 8'd0}, 2'b10,
                  8'h5A, 20, 0, 0, 2'b10, 0, 8'h5A);
    vecs[3] = mkv(0, 2'b11, {32'h1111_2222, 32'h3333_4444}, {8'd2, 8'd3}, {8'd1, 8'd0}, 2'b10,
                  8'h66, 20, 0, 0, 2'b01, 0, 8'h66);
    vecs[4] = mkv(0, 2'b11, {32'h1111_2222, 32'h3333_4444}, {8'd2, 8'd3}, {8'd1, 8'd0}, 2'b10,
                  8'h77, 20, 0, 0, 2'b10, 0, 8'h77);
    vecs[5] = mkv(0, 2'b10, {32'h7830_0801, 32'h0000_0000}, {8'd3, 8'd0}, {8'd1, 8'd0}, 2'b10,
                  8'hA5, 40, 0, 0, 2'b10, 0, 8'hA5);
    vecs[6] = mkv(0, 2'b01, {32'h0000_0000, 32'h5555_AAAA}, {8'd0, 8'd2}, 16'h0000, 2'b00,
                  8'h00, 40, 1, 0, 2'b01, 1, 8'h00);
    vecs[7] = mkv(0, 2'b01, {32'h0000_0000, 32'hCAFE_0001}, {8'd0, 8'd5}, 16'h0000, 2'b00,
                  8'h9C, 30, 0, 1, 2'b01, 0, 8'h9C);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      if (v.rst) begin
        rst_n = 1'b0;
        req_i = '0;
        @(negedge clk_i);
        chk($sformatf("v%0d reset_ctrl", i), 64'({gnt_o, done_o, err_o, iic_en}), 64'd0);
        chk($sformatf("v%0d reset_data", i), 64'({rd_data_o, iic_wr_data, iic_wr_cnt, iic_rd_cnt, iic_mode}), 64'd0);
        rst_n = 1'b1;
      end
      busy_len      = v.blen;
      mute          = v.mt;
      iic_rd_data   = v.rd_val;
      req_wr_data_i = v.wdata;
      req_wr_cnt_i  = v.wcnt;
      req_rd_cnt_i  = v.rcnt;
      req_mode_i    = v.mode;
      req_i         = v.req;
      w = (v.egnt == 2'b10);
      push_exp(v.egnt, v.eerr, v.erd,
               w ? v.wdata[63:32] : v.wdata[31:0],
               w ? v.wcnt[15:8] : v.wcnt[7:0],
               w ? v.rcnt[15:8] : v.rcnt[7:0],
               w ? v.mode[1] : v.mode[0],
               v.eerr ? TO : 3, v.poke);
      do_txn($sformatf("v%0d", i));
    end

    // Reset while the master is busy: outputs clear at once, requester 0 regains priority.
    busy_len      = 100;
    mute          = 1'b0;
    iic_rd_data   = 8'h42;
    req_wr_data_i = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
    req_wr_cnt_i  = {8'd6, 8'd7};
    req_rd_cnt_i  = '0;
    req_mode_i    = '0;
    req_i         = 2'b01;
    cyc = 0;
    while (!(iic_busy && !iic_en) && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("midrun busy_reached", 64'(iic_busy), 64'd1);
    repeat (10) @(negedge clk_i);
    chk("midrun gnt_before", 64'(gnt_o), 64'd1);
    #5 rst_n = 1'b0;
    #1;
    chk("midrun async_ctrl", 64'({gnt_o, done_o, err_o, iic_en}), 64'd0);
    chk("midrun async_data", 64'({rd_data_o, iic_wr_data, iic_wr_cnt, iic_rd_cnt, iic_mode}), 64'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    req_i = 2'b11;
    push_exp(2'b01, 0, 8'h42, 32'hA0A0_A0A0, 8'd7, 8'd0, 1'b0, 1, 0);
    do_txn("post_reset_first");
    push_exp(2'b10, 0, 8'h42, 32'hB1B1_B1B1, 8'd6, 8'd0, 1'b0, 3, 0);
    do_txn("post_reset_second");
    req_i = '0;
    repeat (3) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
